// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Word-wide memory bus between the load/store unit and memory, using a
// waitrequest handshake.
//   address      word-aligned byte address (low two bits always zero)
//   read, write  access strobes; never high together
//   writedata    store data
//   byteenable   active byte lanes of the addressed word
//   readdata     load data returned by memory
//   waitrequest  memory stall; the master holds the strobe and address while high
// Modports: master (load/store unit side), slave (memory side).
interface load_store_unit_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-access stage. It adds the base register to the sign-extended I-type
// immediate to form the effective address. It then runs one bus transaction:
// LW, LB or SW. LW returns the full word. LB returns the selected byte,
// sign-extended. Each completed access produces a one-cycle done pulse.
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   start                   request a transaction (sampled only when idle)
//   opcode, base            instruction opcode and rs value
//   signed_itype_immediate  extended offset
//   store_data              rt value written by SW
//   busy                    transaction in flight (through the done cycle)
//   done, error             completion pulse and its error flag
//   load_result             last load data, held until the next done
//   bus                     master side of the memory bus
// All outputs come straight from flops.
module load_store_unit #(
  parameter logic [5:0] OPCODE_LB = 6'h20,
  parameter logic [5:0] OPCODE_LW = 6'h23,
  parameter logic [5:0] OPCODE_SW = 6'h2B
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [5:0]           opcode,
  input  logic [31:0]          base,
  input  logic [31:0]          signed_itype_immediate,
  input  logic [31:0]          store_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          load_result,
  load_store_unit_if.master    bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [31:0] load_result_q, load_result_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [1:0]  lane_q, lane_d;
  logic        is_lb_q, is_lb_d;

  logic [31:0] ea;
  logic [7:0]  sel_byte;

  // The effective address wraps modulo 2^32. The alignment check looks at
  // the wrapped value.
  assign ea = base + signed_itype_immediate;

  // This picks the byte that an LB addresses. The lane is latched at accept
  // time, so later input changes cannot move it.
  always_comb begin
    sel_byte = bus.readdata[7:0];
    case (lane_q)
      2'd0:    sel_byte = bus.readdata[7:0];
      2'd1:    sel_byte = bus.readdata[15:8];
      2'd2:    sel_byte = bus.readdata[23:16];
      default: sel_byte = bus.readdata[31:24];
    endcase
  end

  // Next-state and registered-output logic. Each output flop is loaded with
  // the value it must show while the FSM sits in the next state. The strobes
  // and done therefore change on the same edge as the state.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = error_q;
    load_result_d = load_result_q;
    address_d     = address_q;
    read_d        = read_q;
    write_d       = write_q;
    writedata_d   = writedata_q;
    byteenable_d  = byteenable_q;
    lane_d        = lane_q;
    is_lb_d       = is_lb_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          address_d = {ea[31:2], 2'b00};
          lane_d    = ea[1:0];
          is_lb_d   = (opcode == OPCODE_LB);
          error_d   = 1'b0;
          if (opcode == OPCODE_LB) begin
            state_d      = READ;
            read_d       = 1'b1;
            byteenable_d = 4'b0001 << ea[1:0];
          end else if (opcode == OPCODE_LW && ea[1:0] == 2'b00) begin
            state_d      = READ;
            read_d       = 1'b1;
            byteenable_d = 4'b1111;
          end else if (opcode == OPCODE_SW && ea[1:0] == 2'b00) begin
            state_d      = WRITE;
            write_d      = 1'b1;
            writedata_d  = store_data;
            byteenable_d = 4'b1111;
          end else begin
            // Misaligned word accesses and unknown opcodes never reach the bus.
            state_d      = DONE;
            done_d       = 1'b1;
            error_d      = 1'b1;
            byteenable_d = 4'b0000;
          end
        end
      end
      READ: begin
        if (!bus.waitrequest) begin
          state_d       = DONE;
          read_d        = 1'b0;
          done_d        = 1'b1;
          load_result_d = is_lb_q ? {{24{sel_byte[7]}}, sel_byte} : bus.readdata;
        end
      end
      WRITE: begin
        if (!bus.waitrequest) begin
          state_d = DONE;
          write_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous, so the strobes drop
  // the moment reset rises, even in the middle of a transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      load_result_q <= 32'h0;
      address_q     <= 32'h0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      writedata_q   <= 32'h0;
      byteenable_q  <= 4'h0;
      lane_q        <= 2'b00;
      is_lb_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      load_result_q <= load_result_d;
      address_q     <= address_d;
      read_q        <= read_d;
      write_q       <= write_d;
      writedata_q   <= writedata_d;
      byteenable_q  <= byteenable_d;
      lane_q        <= lane_d;
      is_lb_q       <= is_lb_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign load_result    = load_result_q;
  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = writedata_q;
  assign bus.byteenable = byteenable_q;

endmodule
